// File: rtl/matmul_engine_pkg.sv
// rtl/matmul_engine_pkg.sv - shared state encodings and default dimensions for matmul_engine
// Purpose: FSM state type and default matrix/element sizes used by the
//          matmul_engine top level and its matmul_mac accumulator.
// Ports:   none (package).
package matmul_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_MAC   = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int DEF_ROW   = 2;
  localparam int DEF_INNER = 2;
  localparam int DEF_COL   = 2;
  localparam int DEF_DW    = 8;
  localparam int DEF_RW    = 16;

endpackage

// File: rtl/matmul_engine_mac.sv
// rtl/matmul_engine_mac.sv - RW-bit multiply-accumulate register with sync clear and enable
// Purpose: acc <= acc + a*b (unsigned, modulo 2^RW) when en_i; clr_i zeroes acc.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   clr_i      clear accumulator (wins over en_i)
//   en_i       accumulate a_i*b_i this cycle
//   a_i, b_i   DW-bit unsigned operands
//   acc_o      RW-bit accumulator value
module matmul_mac #(
  parameter int DW = 8,
  parameter int RW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [RW-1:0] acc_o
);

  logic [2*DW-1:0] prod;
  logic [RW-1:0]   prod_ext;
  logic [RW-1:0]   acc_q;

  assign prod = a_i * b_i;
  // Full-width product is resized to the accumulator width; the sum wraps.
  assign prod_ext = RW'(prod);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + prod_ext;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/matmul_engine.sv
// rtl/matmul_engine.sv - sequential R = A x B engine writing results into R memory
// Purpose: on a rising edge of start (while idle) walks i/j/k, reads one A and
//          one B element per FETCH, accumulates in MAC, writes each R element
//          row-major, then pulses done once.
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   start                              level request, rising edge starts a run
//   read_A, read_address_A, data_A     A memory read port (data one cycle later)
//   read_B, read_address_B, data_B     B memory read port (data one cycle later)
//   write_R, write_address_R,
//   write_value_R                      R memory write port
//   busy                               high while a run is in progress
//   done                               one-cycle pulse after the last R write
module matmul_engine
  import matmul_engine_pkg::*;
#(
  parameter int ROW   = DEF_ROW,
  parameter int INNER = DEF_INNER,
  parameter int COL   = DEF_COL,
  parameter int DW    = DEF_DW,
  parameter int RW    = DEF_RW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          read_A,
  output logic [31:0]   read_address_A,
  input  logic [DW-1:0] data_A,
  output logic          read_B,
  output logic [31:0]   read_address_B,
  input  logic [DW-1:0] data_B,
  output logic          write_R,
  output logic [31:0]   write_address_R,
  output logic [RW-1:0] write_value_R,
  output logic          busy,
  output logic          done
);

  state_e state_q, state_d;
  logic [31:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic        start_q, start_prev_q;
  logic        start_edge;
  logic        acc_clr, acc_en;
  logic [RW-1:0] acc;

  logic [31:0] addr_a_cur, addr_b_cur, addr_r_cur;
  logic [31:0] addr_a_hold_q, addr_b_hold_q, addr_r_hold_q;
  logic [RW-1:0] wval_hold_q;

  // start is registered twice so the edge is seen one cycle after sampling;
  // this sets the run latency (start sampled at cycle 0, first FETCH at cycle 1).
  assign start_edge = start_q & ~start_prev_q;

  assign addr_a_cur = i_q * 32'(INNER) + k_q;
  assign addr_b_cur = k_q * 32'(COL) + j_q;
  assign addr_r_cur = i_q * 32'(COL) + j_q;

  matmul_mac #(.DW(DW), .RW(RW)) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (acc_clr),
    .en_i  (acc_en),
    .a_i   (data_A),
    .b_i   (data_B),
    .acc_o (acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      i_q           <= '0;
      j_q           <= '0;
      k_q           <= '0;
      start_q       <= 1'b0;
      start_prev_q  <= 1'b0;
      addr_a_hold_q <= '0;
      addr_b_hold_q <= '0;
      addr_r_hold_q <= '0;
      wval_hold_q   <= '0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      j_q          <= j_d;
      k_q          <= k_d;
      start_q      <= start;
      start_prev_q <= start_q;
      if (state_q == ST_FETCH) begin
        addr_a_hold_q <= addr_a_cur;
        addr_b_hold_q <= addr_b_cur;
      end
      if (state_q == ST_WRITE) begin
        addr_r_hold_q <= addr_r_cur;
        wval_hold_q   <= acc;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    read_A  = 1'b0;
    read_B  = 1'b0;
    write_R = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d = ST_FETCH;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_clr = 1'b1;
        end
      end
      ST_FETCH: begin
        read_A  = 1'b1;
        read_B  = 1'b1;
        state_d = ST_MAC;
      end
      ST_MAC: begin
        acc_en = 1'b1;
        if (k_q == 32'(INNER - 1)) begin
          state_d = ST_WRITE;
        end else begin
          k_d     = k_q + 32'd1;
          state_d = ST_FETCH;
        end
      end
      ST_WRITE: begin
        write_R = 1'b1;
        acc_clr = 1'b1;
        k_d     = '0;
        if (j_q < 32'(COL - 1)) begin
          j_d     = j_q + 32'd1;
          state_d = ST_FETCH;
        end else if (i_q < 32'(ROW - 1)) begin
          j_d     = '0;
          i_d     = i_q + 32'd1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Addresses/value follow the counters during their strobe and hold otherwise.
  assign read_address_A  = (state_q == ST_FETCH) ? addr_a_cur : addr_a_hold_q;
  assign read_address_B  = (state_q == ST_FETCH) ? addr_b_cur : addr_b_hold_q;
  assign write_address_R = (state_q == ST_WRITE) ? addr_r_cur : addr_r_hold_q;
  assign write_value_R   = (state_q == ST_WRITE) ? acc : wval_hold_q;
  assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_matmul_engine.sv
// tb/tb_matmul_engine.sv - scoreboard bench for matmul_engine
module tb_matmul_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        read_A, read_B, write_R, busy, done;
  logic [31:0] read_address_A, read_address_B, write_address_R;
  logic [7:0]  data_A, data_B;
  logic [15:0] write_value_R;

  always #5 clk = ~clk;

  matmul_engine dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .read_A          (read_A),
    .read_address_A  (read_address_A),
    .data_A          (data_A),
    .read_B          (read_B),
    .read_address_B  (read_address_B),
    .data_B          (data_B),
    .write_R         (write_R),
    .write_address_R (write_address_R),
    .write_value_R   (write_value_R),
    .busy            (busy),
    .done            (done)
  );

  logic [7:0] mem_a [4];
  logic [7:0] mem_b [4];

  always @(posedge clk) begin
    if (read_A) data_A <= mem_a[read_address_A[1:0]];
    if (read_B) data_B <= mem_b[read_address_B[1:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int val;
  } wr_t;

  wr_t exp_q[$];
  int  done_q[$];
  int  start_ref = 0;
  int  writes = 0;
  int  dones = 0;
  int  total = 0;
  int  bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops expected writes and done timing whenever the DUT presents them.
  always @(negedge clk) begin
    if (write_R) begin
      writes++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_write: got write addr %0d value %0d, none expected", write_address_R, write_value_R);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 64'(write_address_R), 64'(e.addr));
        check("write_value", 64'(write_value_R), 64'(e.val));
      end
    end
    if (done) begin
      dones++;
      if (done_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_done: got done at cycle %0d, none expected", cyc - start_ref);
      end else begin
        check("done_cycle", 64'(cyc - start_ref), 64'(done_q.pop_front()));
      end
    end
  end

  task automatic push_run(input int v0, input int v1, input int v2, input int v3);
    exp_q.push_back('{0, v0});
    exp_q.push_back('{1, v1});
    exp_q.push_back('{2, v2});
    exp_q.push_back('{3, v3});
    done_q.push_back(21);
  endtask

  // Raise start so that the next posedge is cycle 0 of the run.
  task automatic edge_start();
    @(negedge clk);
    start = 1'b1;
    start_ref = cyc + 1;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (dones < target && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("run_completed", 64'(dones), 64'(target));
  endtask

  task automatic idle_checks(input string tag);
    @(negedge clk);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int d0, w0;
    rst   = 1'b1;
    start = 1'b0;
    mem_a = '{8'd1, 8'd2, 8'd3, 8'd4};
    mem_b = '{8'd5, 8'd6, 8'd7, 8'd8};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_read_A", 64'(read_A), 64'd0);
    check("rst_read_B", 64'(read_B), 64'd0);
    check("rst_write_R", 64'(write_R), 64'd0);
    check("rst_addr_A", 64'(read_address_A), 64'd0);
    check("rst_addr_R", 64'(write_address_R), 64'd0);
    check("rst_value_R", 64'(write_value_R), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: basic 2x2 product
    push_run(19, 22, 43, 50);
    edge_start();
    @(negedge clk);
    check("t1_busy_cycle0", 64'(busy), 64'd0);
    @(negedge clk);
    check("t1_busy_cycle1", 64'(busy), 64'd1);
    start = 1'b0;
    wait_done(1);
    idle_checks("t1");

    // 2: all-ones operands wrap modulo 2^16
    mem_a = '{8'd255, 8'd255, 8'd255, 8'd255};
    mem_b = '{8'd255, 8'd255, 8'd255, 8'd255};
    push_run(64514, 64514, 64514, 64514);
    edge_start();
    @(negedge clk);
    start = 1'b0;
    wait_done(2);
    idle_checks("t2");

    // 3: identity B
    mem_a = '{8'd9, 8'd8, 8'd7, 8'd6};
    mem_b = '{8'd1, 8'd0, 8'd0, 8'd1};
    w0 = writes;
    push_run(9, 8, 7, 6);
    edge_start();
    @(negedge clk);
    start = 1'b0;
    wait_done(3);
    idle_checks("t3");
    check("t3_write_count", 64'(writes - w0), 64'd4);

    // 4: second edge at cycle 6 is dropped; an edge after done reruns
    mem_a = '{8'd1, 8'd2, 8'd3, 8'd4};
    mem_b = '{8'd5, 8'd6, 8'd7, 8'd8};
    w0 = writes;
    push_run(19, 22, 43, 50);
    edge_start();
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    wait_done(4);
    repeat (10) @(negedge clk);
    check("t4_single_done", 64'(dones), 64'd4);
    check("t4_write_count", 64'(writes - w0), 64'd4);
    start = 1'b0;
    push_run(19, 22, 43, 50);
    edge_start();
    @(negedge clk);
    start = 1'b0;
    wait_done(5);
    idle_checks("t4b");

    // 5: reset sampled at cycle 7 aborts after the first write
    w0 = writes;
    d0 = dones;
    exp_q.push_back('{0, 19});
    edge_start();
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_outputs", 64'({read_A, read_B, write_R, done}), 64'd0);
    check("t5_addrs", 64'(read_address_A | read_address_B | write_address_R), 64'd0);
    check("t5_value", 64'(write_value_R), 64'd0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("t5_write_count", 64'(writes - w0), 64'd1);
    check("t5_no_done", 64'(dones - d0), 64'd0);
    push_run(19, 22, 43, 50);
    edge_start();
    @(negedge clk);
    start = 1'b0;
    wait_done(d0 + 1);
    idle_checks("t5b");

    // 6: start held high across a run gives one run; low-then-high retriggers
    mem_a = '{8'd2, 8'd0, 8'd1, 8'd3};
    mem_b = '{8'd4, 8'd1, 8'd2, 8'd5};
    d0 = dones;
    push_run(8, 2, 10, 16);
    edge_start();
    wait_done(d0 + 1);
    repeat (30) @(negedge clk);
    check("t6_held_single_run", 64'(dones - d0), 64'd1);
    start = 1'b0;
    push_run(8, 2, 10, 16);
    edge_start();
    wait_done(d0 + 2);
    @(negedge clk);
    start = 1'b0;
    idle_checks("t6b");

    check("final_done_queue", 64'(done_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
